// File: rtl/uart_frame_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | uart_frame_arbiter                                                       |
// | Round-robin arbiter framing source payloads onto one byte-level UART TX. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_frame_arbiter #(
   parameter int          NUM_REQ       = 2,
   parameter int          PAYLOAD_BYTES = 20,
   parameter logic [7:0]  HEADER        = 8'h5A
) (
   input  logic                                clk_50m,
   input  logic                                rst_n,
   input  logic [NUM_REQ-1:0]                  req,
   input  logic [NUM_REQ*PAYLOAD_BYTES*8-1:0]  req_data,
   output logic [NUM_REQ-1:0]                  gnt,
   output logic [NUM_REQ-1:0]                  done,
   output logic                                busy,
   output logic                                txd_en,
   output logic [7:0]                          txd_data,
   input  logic                                txd_flag
);

   localparam int         c_PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int         c_PB       = PAYLOAD_BYTES * 8;
   localparam logic [5:0] c_PL_END   = 6'(PAYLOAD_BYTES + 1);
   localparam logic [5:0] c_CK_IDX   = 6'(PAYLOAD_BYTES + 2);
   localparam logic [5:0] c_LAST_IDX = 6'(PAYLOAD_BYTES + 3);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_SEND = 2'd2,
      S_FIN  = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_PTR_W-1:0]   r_ptr;
   logic [c_PTR_W-1:0]   r_sel;
   logic [c_PB-1:0]      r_payload;
   logic [5:0]           r_idx;
   logic [7:0]           r_cksum;
   logic [7:0]           r_txd_data;

   logic                 w_found;
   logic [c_PTR_W-1:0]   w_win;
   logic [c_PTR_W-1:0]   w_cand;
   logic [c_PB-1:0]      w_slice;
   logic [7:0]           w_next_byte;
   logic [NUM_REQ-1:0]   w_sel_oh;

   // Rotating priority scan starting at the round-robin pointer.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_cand = c_PTR_W'((int'(r_ptr) + k) % NUM_REQ);
         if (!w_found && req[w_cand]) begin
            w_found = 1'b1;
            w_win   = w_cand;
         end
      end
   end

   always_comb begin
      w_slice = '0;
      for (int s = 0; s < NUM_REQ; s++) begin
         if (r_sel == c_PTR_W'(s)) begin
            w_slice = req_data[s*c_PB +: c_PB];
         end
      end
   end

   assign w_sel_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_sel;

   // Byte that follows the one at r_idx; the checksum is closed with the
   // last payload byte still sitting on txd_data.
   always_comb begin
      w_next_byte = HEADER;
      if (r_idx == 6'd1) begin
         w_next_byte = 8'(r_sel);
      end else if (r_idx >= 6'd2 && r_idx <= c_PL_END) begin
         w_next_byte = r_payload[c_PB-1 -: 8];
      end else if (r_idx == c_CK_IDX) begin
         w_next_byte = r_cksum + r_txd_data;
      end
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      gnt         = '0;
      done        = '0;
      busy        = 1'b0;
      txd_en      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            gnt         = w_sel_oh;
            busy        = 1'b1;
            w_state_nxt = S_SEND;
         end
         S_SEND: begin
            gnt    = w_sel_oh;
            busy   = 1'b1;
            txd_en = 1'b1;
            if (txd_flag && r_idx == c_LAST_IDX) begin
               w_state_nxt = S_FIN;
            end
         end
         S_FIN: begin
            done        = w_sel_oh;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr      <= '0;
         r_sel      <= '0;
         r_payload  <= '0;
         r_idx      <= '0;
         r_cksum    <= '0;
         r_txd_data <= 8'h00;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_sel <= w_win;
               end
            end
            S_LOAD: begin
               r_payload  <= w_slice;
               r_idx      <= '0;
               r_cksum    <= '0;
               r_txd_data <= HEADER;
            end
            S_SEND: begin
               if (txd_flag && r_idx != c_LAST_IDX) begin
                  r_idx      <= r_idx + 6'd1;
                  r_txd_data <= w_next_byte;
                  if (r_idx >= 6'd2) begin
                     r_cksum <= r_cksum + r_txd_data;
                  end
                  if (r_idx >= 6'd2 && r_idx <= c_PL_END) begin
                     r_payload <= r_payload << 8;
                  end
               end
            end
            S_FIN: begin
               r_ptr <= (r_sel == c_PTR_W'(NUM_REQ-1)) ? '0 : r_sel + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign txd_data = r_txd_data;

endmodule
`default_nettype wire
